ctrl_pipe_rv32i: RTL and testbench
==================================

Name: ctrl_pipe_rv32i

Overview:
- Next-generation control unit for the 5-stage RV32I core.
- Decodes opcode and funct3 in the ID stage and drives the ID-stage immediate-format select combinationally.
- Carries the remaining control bundle through ID/EX, EX/MEM and MEM/WB registers, with stall and flush support.
- Adds LUI, AUIPC, JALR, bubble insertion and parametrised memory-latency stages.

Parameters:
- IMM_SRC_W, 3, width of the immediate-format select; must be ≥3.
- RES_SRC_W, 2, width of the writeback result select; must be ≥2.
- MEM_LAT, 1, number of EX/MEM-to-WB register stages for memory controls; legal range 1..4.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- op_d  in  7  instruction[6:0] in ID
- funct3_d  in  3  instruction[14:12] in ID
- valid_d  in  1  ID holds a real instruction
- stall  in  1  freeze all control registers
- flush_e  in  1  insert bubble into EX
- imm_src_d  out  IMM_SRC_W  combinational immediate format for the ID immediate generator
- alu_src_a_e  out  1  0=rs1, 1=PC
- alu_src_b_e  out  1  0=rs2, 1=imm
- alu_op_e  out  2  00 add, 01 sub, 10 use funct fields
- branch_e  out  1  conditional branch
- jump_e  out  1  JAL
- jump_reg_e  out  1  JALR (target from rs1+imm)
- funct3_e  out  3  registered funct3 for branch/load sizing
- mem_write_m  out  1  store
- mem_read_m  out  1  load
- reg_write_w  out  1  register-file write enable
- result_src_w  out  RES_SRC_W  00 ALU, 01 memory, 10 PC+4, 11 immediate

Behaviour:
- Decode is combinational; all unlisted controls are 0.
  - 0110011 R: reg_write, alu_op=10.
  - 0010011 I-ALU: reg_write, alu_src_b, imm=000, alu_op=10.
  - 0000011 load: reg_write, alu_src_b, mem_read, imm=000, result=01.
  - 0100011 store: mem_write, alu_src_b, imm=001.
  - 1100011 branch: branch, imm=010, alu_op=01.
  - 1101111 JAL: jump, reg_write, imm=011, result=10.
  - 1100111 JALR: jump_reg, reg_write, alu_src_b, imm=000, result=10.
  - 0110111 LUI: reg_write, imm=100, result=11.
  - 0010111 AUIPC: reg_write, alu_src_a, alu_src_b, imm=100.
  - 0001111 FENCE and 1110011 SYSTEM: no-op, all controls 0.
- imm_src_d follows op_d with zero latency; upper bits beyond 3 are zero.
- Bubble: all-zero bundle. Injected into EX when valid_d=0, when flush_e=1, or for an unrecognised opcode.
- Latency from ID decode:
  - EX outputs: 1 cycle.
  - mem_*_m: 2 cycles.
  - reg_write_w and result_src_w: 2+MEM_LAT cycles.
  - With MEM_LAT>1, mem_*_m is asserted only in the first memory stage; the remaining stages carry only the writeback fields.
- stall=1: every control register holds, including the memory-latency stages.
  - stall has priority over flush_e; flush_e raised during stall is ignored, so the hazard unit must hold it until stall drops.
- stall=0 and flush_e=1: EX loads a bubble; downstream stages advance normally.
- Reset: on the rising edge with rst=1, all registered outputs go to 0 the next cycle regardless of stall or flush. Reset mid-stream discards every in-flight bundle. imm_src_d is unaffected by reset.
- Back-to-back identical instructions produce independent bundles; there is no coalescing.

Optional Feature:
- Macro: CTRL_ILLEGAL_FLAG_EN.
- When defined:
  - Adds output illegal_e (1 bit). It asserts in EX for a bundle decoded from an unrecognised opcode with valid_d=1.
  - It is also asserted for op_d[1:0]≠11.
  - The flag follows the same stall, flush and reset rules; flush_e clears it.
- When undefined:
  - The port is absent.
  - Illegal opcodes silently become bubbles.

Test Plan:
- Reset, then R-type: op_d=0110011, valid_d=1 → at cycle+1 alu_op_e=10 and alu_src_b_e=0; at cycle+3 (MEM_LAT=1) reg_write_w=1 and result_src_w=00.
- Load then store back-to-back: 0000011, then 0100011 → mem_read_m=1 at cycle+2 and mem_write_m=1 at cycle+3; reg_write_w=1 and result_src_w=01 at cycle+3 only.
- LUI/AUIPC/JALR: imm_src_d=100 same cycle for LUI/AUIPC. EX shows alu_src_a_e=1 for AUIPC and jump_reg_e=1 for JALR. result_src_w=11 for LUI and 10 for JALR.
- Flush and stall:
  - Branch with flush_e=1 → EX bundle all zero.
  - Load with stall held 2 cycles → outputs frozen 2 cycles, then advance; flush_e during stall has no effect.
- MEM_LAT=3 with a load → mem_read_m at cycle+2, reg_write_w at cycle+5.
- Mid-stream rst=1 → all outputs 0 the next cycle. With CTRL_ILLEGAL_FLAG_EN, op_d=0000000 and valid_d=1 → illegal_e=1 at cycle+1 and all other controls 0.

Source files
------------

// File: rtl/ctrl_pipe_rv32i.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_rv32i
//
// Control unit for a 5-stage RV32I pipeline. The opcode is decoded in ID.
// The immediate-format select is driven straight back to the ID immediate
// generator. The rest of the control bundle is registered through ID/EX,
// EX/MEM, MEM_LAT-1 extra memory-latency stages and MEM/WB.
//
// Parameters:
//   IMM_SRC_W  width of imm_src_d (>= 3, bits above [2:0] are zero)
//   RES_SRC_W  width of result_src_w (>= 2, bits above [1:0] are zero)
//   MEM_LAT    number of EX/MEM-to-WB memory stages, 1..4
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   op_d, funct3_d    instruction[6:0] / [14:12] in ID
//   valid_d           ID holds a real instruction
//   stall             freeze every control register
//   flush_e           load a bubble into EX (ignored while stall=1)
//   imm_src_d         combinational immediate format for ID
//   alu_src_a_e ..    EX-stage controls and registered funct3
//   mem_write_m/read  controls in the first memory stage
//   reg_write_w,
//   result_src_w      writeback controls, 2+MEM_LAT cycles after decode
//
// Optional feature (macro CTRL_ILLEGAL_FLAG_EN):
//   Adds output illegal_e, set in EX for a valid instruction whose opcode is
//   not recognised (including any opcode with op[1:0] != 2'b11). Without the
//   macro such instructions silently become bubbles.
// ---------------------------------------------------------------------------
module ctrl_pipe_rv32i #(
  parameter int IMM_SRC_W = 3,
  parameter int RES_SRC_W = 2,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op_d,
  input  logic [2:0]           funct3_d,
  input  logic                 valid_d,
  input  logic                 stall,
  input  logic                 flush_e,
  output logic [IMM_SRC_W-1:0] imm_src_d,
  output logic                 alu_src_a_e,
  output logic                 alu_src_b_e,
  output logic [1:0]           alu_op_e,
  output logic                 branch_e,
  output logic                 jump_e,
  output logic                 jump_reg_e,
  output logic [2:0]           funct3_e,
  output logic                 mem_write_m,
  output logic                 mem_read_m,
  output logic                 reg_write_w,
  output logic [RES_SRC_W-1:0] result_src_w
`ifdef CTRL_ILLEGAL_FLAG_EN
  ,
  output logic                 illegal_e
`endif
);

  // -------------------------------------------------------------------------
  // ID-stage decode
  // -------------------------------------------------------------------------
  logic [2:0] imm_fmt;
  logic       dec_reg_write;
  logic       dec_alu_src_a;
  logic       dec_alu_src_b;
  logic [1:0] dec_alu_op;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_jump_reg;
  logic       dec_mem_write;
  logic       dec_mem_read;
  logic [1:0] dec_result;
  logic       dec_known;  // opcode is one of the recognised RV32I groups
  logic       dec_noop;   // FENCE / SYSTEM: recognised but carries nothing

  always_comb begin
    imm_fmt       = 3'b000;
    dec_reg_write = 1'b0;
    dec_alu_src_a = 1'b0;
    dec_alu_src_b = 1'b0;
    dec_alu_op    = 2'b00;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_jump_reg  = 1'b0;
    dec_mem_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_result    = 2'b00;
    dec_known     = 1'b1;
    dec_noop      = 1'b0;
    case (op_d)
      7'b0110011: begin  // R-type
        dec_reg_write = 1'b1;
        dec_alu_op    = 2'b10;
      end
      7'b0010011: begin  // I-type ALU
        dec_reg_write = 1'b1;
        dec_alu_src_b = 1'b1;
        dec_alu_op    = 2'b10;
      end
      7'b0000011: begin  // load
        dec_reg_write = 1'b1;
        dec_alu_src_b = 1'b1;
        dec_mem_read  = 1'b1;
        dec_result    = 2'b01;
      end
      7'b0100011: begin  // store
        dec_mem_write = 1'b1;
        dec_alu_src_b = 1'b1;
        imm_fmt       = 3'b001;
      end
      7'b1100011: begin  // conditional branch
        dec_branch = 1'b1;
        dec_alu_op = 2'b01;
        imm_fmt    = 3'b010;
      end
      7'b1101111: begin  // JAL
        dec_jump      = 1'b1;
        dec_reg_write = 1'b1;
        imm_fmt       = 3'b011;
        dec_result    = 2'b10;
      end
      7'b1100111: begin  // JALR
        dec_jump_reg  = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src_b = 1'b1;
        dec_result    = 2'b10;
      end
      7'b0110111: begin  // LUI: the immediate itself is written back
        dec_reg_write = 1'b1;
        imm_fmt       = 3'b100;
        dec_result    = 2'b11;
      end
      7'b0010111: begin  // AUIPC: PC + U-immediate through the ALU
        dec_reg_write = 1'b1;
        dec_alu_src_a = 1'b1;
        dec_alu_src_b = 1'b1;
        imm_fmt       = 3'b100;
      end
      7'b0001111, 7'b1110011: begin  // FENCE, SYSTEM
        dec_noop = 1'b1;
      end
      default: begin
        dec_known = 1'b0;
      end
    endcase
  end

  assign imm_src_d = IMM_SRC_W'(imm_fmt);

  // A real bundle enters EX only for a valid, recognised, unflushed
  // instruction; everything else becomes the all-zero bubble. Unrecognised
  // opcodes already decode to all-zero controls, so only funct3 needs gating.
  logic       take_e;
  logic [2:0] funct3_next;

  assign take_e      = valid_d & dec_known & ~flush_e;
  assign funct3_next = (take_e & ~dec_noop) ? funct3_d : 3'b000;

  // -------------------------------------------------------------------------
  // ID/EX register
  // -------------------------------------------------------------------------
  logic                 alu_src_a_reg;
  logic                 alu_src_b_reg;
  logic [1:0]           alu_op_reg;
  logic                 branch_reg;
  logic                 jump_reg;
  logic                 jump_reg_reg;
  logic [2:0]           funct3_reg;
  logic                 mem_write_e_reg;
  logic                 mem_read_e_reg;
  logic                 reg_write_e_reg;
  logic [RES_SRC_W-1:0] result_e_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_src_a_reg   <= 1'b0;
      alu_src_b_reg   <= 1'b0;
      alu_op_reg      <= 2'b00;
      branch_reg      <= 1'b0;
      jump_reg        <= 1'b0;
      jump_reg_reg    <= 1'b0;
      funct3_reg      <= 3'b000;
      mem_write_e_reg <= 1'b0;
      mem_read_e_reg  <= 1'b0;
      reg_write_e_reg <= 1'b0;
      result_e_reg    <= '0;
    end else if (!stall) begin
      alu_src_a_reg   <= take_e & dec_alu_src_a;
      alu_src_b_reg   <= take_e & dec_alu_src_b;
      alu_op_reg      <= take_e ? dec_alu_op : 2'b00;
      branch_reg      <= take_e & dec_branch;
      jump_reg        <= take_e & dec_jump;
      jump_reg_reg    <= take_e & dec_jump_reg;
      funct3_reg      <= funct3_next;
      mem_write_e_reg <= take_e & dec_mem_write;
      mem_read_e_reg  <= take_e & dec_mem_read;
      reg_write_e_reg <= take_e & dec_reg_write;
      result_e_reg    <= take_e ? RES_SRC_W'(dec_result) : '0;
    end
  end

  assign alu_src_a_e = alu_src_a_reg;
  assign alu_src_b_e = alu_src_b_reg;
  assign alu_op_e    = alu_op_reg;
  assign branch_e    = branch_reg;
  assign jump_e      = jump_reg;
  assign jump_reg_e  = jump_reg_reg;
  assign funct3_e    = funct3_reg;

`ifdef CTRL_ILLEGAL_FLAG_EN
  // op[1:0] != 2'b11 can never match a recognised opcode, but it is named
  // explicitly so the intent survives any future opcode additions.
  logic illegal_next;
  logic illegal_reg;

  assign illegal_next = valid_d & ~flush_e &
                        (~dec_known | (op_d[1:0] != 2'b11));

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_reg <= 1'b0;
    end else if (!stall) begin
      illegal_reg <= illegal_next;
    end
  end

  assign illegal_e = illegal_reg;
`endif

  // -------------------------------------------------------------------------
  // Memory stages. Stage 0 is EX/MEM and the only one carrying the memory
  // strobes; later stages just delay the writeback fields.
  // -------------------------------------------------------------------------
  logic mem_write_reg;
  logic mem_read_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
    end else if (!stall) begin
      mem_write_reg <= mem_write_e_reg;
      mem_read_reg  <= mem_read_e_reg;
    end
  end

  assign mem_write_m = mem_write_reg;
  assign mem_read_m  = mem_read_reg;

  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_mem
    logic                 rw_reg;
    logic [RES_SRC_W-1:0] res_reg;
    logic                 rw_in;
    logic [RES_SRC_W-1:0] res_in;

    if (gi == 0) begin : g_src_ex
      assign rw_in  = reg_write_e_reg;
      assign res_in = result_e_reg;
    end else begin : g_src_prev
      assign rw_in  = g_mem[gi-1].rw_reg;
      assign res_in = g_mem[gi-1].res_reg;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rw_reg  <= 1'b0;
        res_reg <= '0;
      end else if (!stall) begin
        rw_reg  <= rw_in;
        res_reg <= res_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // MEM/WB register
  // -------------------------------------------------------------------------
  logic                 reg_write_w_reg;
  logic [RES_SRC_W-1:0] result_w_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_w_reg <= 1'b0;
      result_w_reg    <= '0;
    end else if (!stall) begin
      reg_write_w_reg <= g_mem[MEM_LAT-1].rw_reg;
      result_w_reg    <= g_mem[MEM_LAT-1].res_reg;
    end
  end

  assign reg_write_w  = reg_write_w_reg;
  assign result_src_w = result_w_reg;

endmodule

// File: tb/tb_ctrl_pipe_rv32i.sv
// ---------------------------------------------------------------------------
// Testbench for ctrl_pipe_rv32i. Two instances (MEM_LAT=1 and MEM_LAT=3)
// receive identical stimulus. The reference model keeps a history of the
// bundles that entered EX, newest first. EX shows entry 0, the first memory
// stage entry 1 and writeback entry 1+MEM_LAT. A stall adds no entry and a
// reset wipes the history. The expected outputs are queued per cycle and a
// separate monitor compares them.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_rv32i;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic       a;
    logic       b;
    logic [1:0] alu_op;
    logic       br;
    logic       j;
    logic       jr;
    logic [2:0] f3;
    logic       mw;
    logic       mr;
    logic       rw;
    logic [1:0] res;
    logic       ill;
  } bundle_t;

  typedef struct packed {
    logic [2:0] imm;
    bundle_t    ex;
    bundle_t    m;
    bundle_t    w1;
    bundle_t    w3;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op_d = '0;
  logic [2:0] funct3_d = '0;
  logic       valid_d = 1'b0;
  logic       stall = 1'b0;
  logic       flush_e = 1'b0;

  logic [2:0] imm1, imm3, f3_1, f3_3;
  logic [1:0] aop1, aop3, res1, res3;
  logic       sa1, sb1, br1, j1, jr1, mw1, mr1, rw1;
  logic       sa3, sb3, br3, j3, jr3, mw3, mr3, rw3;
  logic       ill1, ill3;

  always #5 clk = ~clk;

  ctrl_pipe_rv32i #(.IMM_SRC_W(3), .RES_SRC_W(2), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d),
    .valid_d(valid_d), .stall(stall), .flush_e(flush_e),
    .imm_src_d(imm1), .alu_src_a_e(sa1), .alu_src_b_e(sb1),
    .alu_op_e(aop1), .branch_e(br1), .jump_e(j1), .jump_reg_e(jr1),
    .funct3_e(f3_1), .mem_write_m(mw1), .mem_read_m(mr1),
    .reg_write_w(rw1), .result_src_w(res1)
`ifdef CTRL_ILLEGAL_FLAG_EN
    , .illegal_e(ill1)
`endif
  );

  ctrl_pipe_rv32i #(.IMM_SRC_W(3), .RES_SRC_W(2), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d),
    .valid_d(valid_d), .stall(stall), .flush_e(flush_e),
    .imm_src_d(imm3), .alu_src_a_e(sa3), .alu_src_b_e(sb3),
    .alu_op_e(aop3), .branch_e(br3), .jump_e(j3), .jump_reg_e(jr3),
    .funct3_e(f3_3), .mem_write_m(mw3), .mem_read_m(mr3),
    .reg_write_w(rw3), .result_src_w(res3)
`ifdef CTRL_ILLEGAL_FLAG_EN
    , .illegal_e(ill3)
`endif
  );

`ifndef CTRL_ILLEGAL_FLAG_EN
  assign ill1 = 1'b0;
  assign ill3 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  exp_t    exp_q[$];
  bundle_t hist[$];

  // Control bundle the specification assigns to an instruction entering EX.
  function automatic bundle_t decode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic valid, input logic flush);
    bundle_t b;
    b = '0;
    if (!valid || flush) return b;
    case (op)
      OP_R:     begin b.rw = 1; b.alu_op = 2'b10; end
      OP_I:     begin b.rw = 1; b.b = 1; b.alu_op = 2'b10; end
      OP_LOAD:  begin b.rw = 1; b.b = 1; b.mr = 1; b.res = 2'b01; end
      OP_STORE: begin b.mw = 1; b.b = 1; end
      OP_BR:    begin b.br = 1; b.alu_op = 2'b01; end
      OP_JAL:   begin b.j = 1; b.rw = 1; b.res = 2'b10; end
      OP_JALR:  begin b.jr = 1; b.rw = 1; b.b = 1; b.res = 2'b10; end
      OP_LUI:   begin b.rw = 1; b.res = 2'b11; end
      OP_AUIPC: begin b.rw = 1; b.a = 1; b.b = 1; end
      OP_FENCE, OP_SYS: return b;
      default: begin
`ifdef CTRL_ILLEGAL_FLAG_EN
        b.ill = 1'b1;
`endif
        return b;
      end
    endcase
    b.f3 = f3;
    return b;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:        return 3'b001;
      OP_BR:           return 3'b010;
      OP_JAL:          return 3'b011;
      OP_LUI, OP_AUIPC: return 3'b100;
      default:         return 3'b000;
    endcase
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic v, input logic st, input logic fl,
                       input logic r);
    exp_t e;
    @(negedge clk);
    op_d = op; funct3_d = f3; valid_d = v; stall = st; flush_e = fl; rst = r;
    if (r) begin
      foreach (hist[i]) hist[i] = '0;
    end else if (!st) begin
      hist.push_front(decode(op, f3, v, fl));
      void'(hist.pop_back());
    end
    e.imm = imm_of(op);
    e.ex  = hist[0];
    e.m   = hist[1];
    e.w1  = hist[2];
    e.w3  = hist[4];
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the registered outputs settle after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imm1", {29'b0, imm1}, {29'b0, e.imm});
        check("imm3", {29'b0, imm3}, {29'b0, e.imm});
        check("ex1", {21'b0, sa1, sb1, aop1, br1, j1, jr1, f3_1},
                     {21'b0, e.ex.a, e.ex.b, e.ex.alu_op, e.ex.br, e.ex.j, e.ex.jr, e.ex.f3});
        check("ex3", {21'b0, sa3, sb3, aop3, br3, j3, jr3, f3_3},
                     {21'b0, e.ex.a, e.ex.b, e.ex.alu_op, e.ex.br, e.ex.j, e.ex.jr, e.ex.f3});
        check("mem1", {30'b0, mw1, mr1}, {30'b0, e.m.mw, e.m.mr});
        check("mem3", {30'b0, mw3, mr3}, {30'b0, e.m.mw, e.m.mr});
        check("wb1", {29'b0, rw1, res1}, {29'b0, e.w1.rw, e.w1.res});
        check("wb3", {29'b0, rw3, res3}, {29'b0, e.w3.rw, e.w3.res});
`ifdef CTRL_ILLEGAL_FLAG_EN
        check("ill1", {31'b0, ill1}, {31'b0, e.ex.ill});
        check("ill3", {31'b0, ill3}, {31'b0, e.ex.ill});
`endif
        $display("cycle t=%0t op=%b v=%b st=%b fl=%b rst=%b ex=%h m=%b%b wb1=%b%b wb3=%b%b",
                 $time, op_d, valid_d, stall, flush_e, rst, e.ex, e.m.mw, e.m.mr,
                 e.w1.rw, e.w1.res, e.w3.rw, e.w3.res);
      end
    end
  end

  logic [6:0] op_tbl [11];

  initial begin
    logic [6:0] op;
    int         idx;
    int         budget;
    for (int i = 0; i < 8; i++) hist.push_back('0);
    op_tbl = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR,
               OP_LUI, OP_AUIPC, OP_FENCE, OP_SYS};

    // Reset
    repeat (3) drive(7'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // R-type, then drain so its writeback is seen in isolation
    drive(OP_R, 3'b101, 1, 0, 0, 0);
    repeat (4) drive(7'b0, 3'b0, 0, 0, 0, 0);
    // Load then store back-to-back
    drive(OP_LOAD, 3'b010, 1, 0, 0, 0);
    drive(OP_STORE, 3'b010, 1, 0, 0, 0);
    // LUI / AUIPC / JALR / JAL / I-ALU
    drive(OP_LUI, 3'b111, 1, 0, 0, 0);
    drive(OP_AUIPC, 3'b011, 1, 0, 0, 0);
    drive(OP_JALR, 3'b000, 1, 0, 0, 0);
    drive(OP_JAL, 3'b110, 1, 0, 0, 0);
    drive(OP_I, 3'b001, 1, 0, 0, 0);
    // Branch flushed out of EX
    drive(OP_BR, 3'b001, 1, 0, 1, 0);
    // Load held by a 2-cycle stall with flush raised during the stall
    drive(OP_LOAD, 3'b100, 1, 0, 0, 0);
    drive(OP_STORE, 3'b000, 1, 1, 1, 0);
    drive(OP_STORE, 3'b000, 1, 1, 0, 0);
    drive(OP_STORE, 3'b000, 1, 0, 0, 0);
    // FENCE, SYSTEM, illegal opcodes
    drive(OP_FENCE, 3'b101, 1, 0, 0, 0);
    drive(OP_SYS, 3'b001, 1, 0, 0, 0);
    drive(7'b0000000, 3'b011, 1, 0, 0, 0);
    drive(7'b0010010, 3'b000, 1, 0, 0, 0);
    drive(OP_R, 3'b000, 1, 0, 0, 0);
    // Mid-stream reset with stall and flush also raised
    drive(OP_LOAD, 3'b000, 1, 1, 1, 1);
    drive(OP_R, 3'b000, 1, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      idx = $urandom_range(0, 13);
      op = (idx < 11) ? op_tbl[idx] : 7'($urandom);
      drive(op, 3'($urandom),
            ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 3));
    end
    repeat (6) drive(7'b0, 3'b0, 0, 0, 0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
